// File: rtl/booth_product_accumulator_if.sv
// Handshake bundle between a product source, the accumulator and a result consumer.
// Latency: none; this is wiring only.
// Backpressure: in_valid/in_ready on the product side and out_valid/out_ready on the result side.
// Ports: in_valid, in_prod, in_last and out_ready come from the master. in_ready, out_valid,
//        out_acc, out_terms and out_ovf come from the slave (the accumulator).
interface booth_product_accumulator_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [7:0]        out_terms;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_terms, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_terms, out_ovf
    );
endinterface

// File: rtl/booth_product_accumulator.sv
// Sums a burst of signed Booth products into one wide signed result with term count and sticky overflow.
// Latency: 1 clk from the closing accept to out_valid.
// Backpressure: a held result stalls input unless it drains in the same cycle; bursts may idle indefinitely.
// Ports: clk, rst_n (synchronous, active low), and bus (slave modport of booth_product_accumulator_if).
// Build option ACC_SATURATE_EN: overflowing partial sums clamp to the ACC_W signed limits instead of wrapping.
module booth_product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int TERMS  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    booth_product_accumulator_if.slave   bus
);
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [7:0] TERMS_B = 8'(TERMS);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] res_acc_q, res_acc_d;
    logic [7:0]       res_terms_q, res_terms_d;
    logic             res_ovf_q, res_ovf_d;

    logic             accept;
    logic             drain;
    logic             close;
    logic [ACC_W:0]   sum;
    logic             sum_ovf;
    logic [ACC_W-1:0] sum_sel;
    logic [7:0]       count_inc;

    assign bus.in_ready  = (state_q == ACCUM) || bus.out_ready;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_acc   = res_acc_q;
    assign bus.out_terms = res_terms_q;
    assign bus.out_ovf   = res_ovf_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign drain     = bus.out_valid && bus.out_ready;
    assign count_inc = count_q + 8'd1;
    assign close     = bus.in_last || (count_inc == TERMS_B);

    // One guard bit: the two top bits disagree exactly when the true sum left the ACC_W range.
    assign sum     = {acc_q[ACC_W-1], acc_q}
                   + {{(ACC_W + 1 - PROD_W){bus.in_prod[PROD_W-1]}}, bus.in_prod};
    assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];

`ifdef ACC_SATURATE_EN
    // The guard bit carries the true sign, so it picks which limit to clamp to.
    always_comb begin
        sum_sel = sum[ACC_W-1:0];
        if (sum_ovf) begin
            sum_sel = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign sum_sel = sum[ACC_W-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        res_acc_d   = res_acc_q;
        res_terms_d = res_terms_q;
        res_ovf_d   = res_ovf_q;

        // A held result retires first; a beat accepted in the same cycle then starts from the
        // cleared accumulator (acc/count/ovf are zeroed whenever a burst closes).
        if (drain) begin
            state_d = ACCUM;
        end

        if (accept) begin
            if (close) begin
                state_d     = HOLD;
                res_acc_d   = sum_sel;
                res_terms_d = count_inc;
                res_ovf_d   = ovf_q | sum_ovf;
                acc_d       = '0;
                count_d     = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d   = sum_sel;
                count_d = count_inc;
                ovf_d   = ovf_q | sum_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            res_acc_q   <= '0;
            res_terms_q <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            res_acc_q   <= res_acc_d;
            res_terms_q <= res_terms_d;
            res_ovf_q   <= res_ovf_d;
        end
    end
endmodule

// File: tb/tb_booth_product_accumulator.sv
// Self-checking bench: two accumulators (ACC_W 16 and 9) share one random product stream.
// Latency: outputs checked on every falling edge against a burst-level integer model.
// Backpressure: random in_valid/out_ready with in_valid held until accepted.
module tb_booth_product_accumulator;
    localparam int TERMS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_prod = 8'd0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    booth_product_accumulator_if #(.PROD_W(8), .ACC_W(16)) ia ();
    booth_product_accumulator_if #(.PROD_W(8), .ACC_W(9))  ib ();

    assign ia.in_valid  = in_valid;
    assign ia.in_prod   = in_prod;
    assign ia.in_last   = in_last;
    assign ia.out_ready = out_ready;
    assign ib.in_valid  = in_valid;
    assign ib.in_prod   = in_prod;
    assign ib.in_last   = in_last;
    assign ib.out_ready = out_ready;

    booth_product_accumulator #(.PROD_W(8), .ACC_W(16), .TERMS(TERMS)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia)
    );

    booth_product_accumulator #(.PROD_W(8), .ACC_W(9), .TERMS(TERMS)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib)
    );

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Running sum over plain integers; out-of-range partial sums wrap by 2^w or clamp.
    function automatic longint fold(input int q[$], input int w, output bit ovf);
        longint s;
        longint mx;
        longint mn;
        s   = 0;
        mx  = (longint'(1) <<< (w - 1)) - 1;
        mn  = -(longint'(1) <<< (w - 1));
        ovf = 1'b0;
        foreach (q[i]) begin
            s = s + q[i];
            if (s > mx || s < mn) begin
                ovf = 1'b1;
`ifdef ACC_SATURATE_EN
                s = (s > mx) ? mx : mn;
`else
                s = (s > mx) ? s - (longint'(1) <<< w) : s + (longint'(1) <<< w);
`endif
            end
        end
        return s;
    endfunction

    // Burst-level model: beats accepted so far, plus the result currently presented.
    int     burst[$];
    bit     m_hold = 1'b0;
    longint m_acc_a = 0;
    longint m_acc_b = 0;
    int     m_terms = 0;
    bit     m_ovf_a = 1'b0;
    bit     m_ovf_b = 1'b0;

    always @(posedge clk) begin : model
        bit acc_ok;
        bit o;
        if (!rst_n) begin
            burst.delete();
            m_hold  = 1'b0;
            m_acc_a = 0;
            m_acc_b = 0;
            m_terms = 0;
            m_ovf_a = 1'b0;
            m_ovf_b = 1'b0;
        end else begin
            acc_ok = in_valid && (!m_hold || out_ready);
            if (m_hold && out_ready) m_hold = 1'b0;
            if (acc_ok) begin
                burst.push_back(int'($signed(in_prod)));
                if (in_last || burst.size() == TERMS) begin
                    m_acc_a = fold(burst, 16, o);
                    m_ovf_a = o;
                    m_acc_b = fold(burst, 9, o);
                    m_ovf_b = o;
                    m_terms = burst.size();
                    m_hold  = 1'b1;
                    burst.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready_a", ia.in_ready, !m_hold || out_ready);
            check("in_ready_b", ib.in_ready, !m_hold || out_ready);
            check("out_valid_a", ia.out_valid, m_hold);
            check("out_valid_b", ib.out_valid, m_hold);
            if (m_hold) begin
                check("out_acc_a", longint'($signed(ia.out_acc)), m_acc_a);
                check("out_acc_b", longint'($signed(ib.out_acc)), m_acc_b);
                check("out_terms_a", ia.out_terms, m_terms);
                check("out_terms_b", ib.out_terms, m_terms);
                check("out_ovf_a", ia.out_ovf, m_ovf_a);
                check("out_ovf_b", ib.out_ovf, m_ovf_b);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic beat(input int p, input bit last);
        bit r;
        int k;
        k        = 0;
        in_valid = 1'b1;
        in_prod  = 8'(p);
        in_last  = last;
        forever begin
            #1 r = ia.in_ready;
            @(posedge clk);
            #1;
            if (r) break;
            k++;
            if (k > 50) begin
                n_cmp++;
                n_err++;
                $display("FAIL beat_timeout: beat %0d not accepted within 50 cycles", p);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain_one();
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
    endtask

    initial begin
        bit pend;

        // Reset held with a valid beat offered: nothing may be taken.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_prod   = 8'd33;
        out_ready = 1'b1;
        cyc(3);
        #1;
        check("rst_out_valid", ia.out_valid, 0);
        check("rst_out_acc", longint'($signed(ia.out_acc)), 0);
        check("rst_out_terms", ia.out_terms, 0);
        check("rst_out_ovf", ia.out_ovf, 0);
        check("rst_out_valid_b", ib.out_valid, 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        cyc(1);

        // Full burst closed by the term limit.
        beat(-6, 0); beat(15, 0); beat(-8, 0); beat(49, 0);
        check("full_valid", ia.out_valid, 1);
        check("full_acc_a", longint'($signed(ia.out_acc)), 50);
        check("full_acc_b", longint'($signed(ib.out_acc)), 50);
        check("full_terms", ia.out_terms, 4);
        check("full_ovf", ia.out_ovf, 0);
        drain_one();

        // Short burst closed by in_last, then stalled with a new beat waiting.
        beat(7, 0); beat(-64, 1);
        in_valid = 1'b1;
        in_prod  = 8'd9;
        in_last  = 1'b0;
        repeat (5) begin
            cyc(1);
            check("stall_acc", longint'($signed(ia.out_acc)), -57);
            check("stall_terms", ia.out_terms, 2);
            check("stall_in_ready", ia.in_ready, 0);
        end

        // Drain and accept in the same cycle; the new burst starts at 9.
        out_ready = 1'b1;
        beat(9, 0);
        out_ready = 1'b0;
        check("drain_accept_valid", ia.out_valid, 0);
        beat(1, 1);
        check("fresh_acc", longint'($signed(ia.out_acc)), 10);
        check("fresh_terms", ia.out_terms, 2);
        drain_one();

        // Overflow in the 9-bit accumulator only.
        beat(127, 0); beat(127, 0); beat(127, 1);
        check("ovf_acc_a", longint'($signed(ia.out_acc)), 381);
        check("ovf_flag_a", ia.out_ovf, 0);
`ifdef ACC_SATURATE_EN
        check("ovf_acc_b", longint'($signed(ib.out_acc)), 255);
`else
        check("ovf_acc_b", longint'($signed(ib.out_acc)), -131);
`endif
        check("ovf_flag_b", ib.out_ovf, 1);
        drain_one();

        // Reset in the middle of a burst discards the partial sum.
        beat(10, 0); beat(20, 0);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        beat(5, 1);
        check("post_rst_acc", longint'($signed(ia.out_acc)), 5);
        check("post_rst_terms", ia.out_terms, 1);
        drain_one();

        // Random traffic with random backpressure, checked by the model every cycle.
        pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || pend) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_prod  = 8'($urandom_range(0, 255));
                in_last  = ($urandom_range(0, 3) == 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1 pend = in_valid && ia.in_ready;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
